// File: rtl/rf_pkg.sv
// Shared register-file types and sizes, used by the writeback path and register_file.
// Optional feature macro used by importers: RF_WB_BYPASS_EN.
package rf_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;
    localparam int NUM_REGS  = 1 << RF_ADDR_W;

    typedef logic [RF_ADDR_W-1:0] rf_idx_t;
    typedef logic [RF_DATA_W-1:0] rf_data_t;

    typedef struct packed {
        rf_idx_t  rd;
        rf_data_t data;
    } wb_req_t;

    // x0 is hardwired zero and never tracked
    function automatic logic rf_idx_live(input rf_idx_t idx);
        return idx != '0;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: set at issue, clear at writeback, set wins on collision.
// RF_WB_BYPASS_EN: the register being written this cycle is masked from the source checks.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         iss_valid_i,
    input  logic [ADDR_WIDTH-1:0]        iss_rd_i,
    input  logic [ADDR_WIDTH-1:0]        iss_rs1_i,
    input  logic [ADDR_WIDTH-1:0]        iss_rs2_i,
    input  logic                         clr_en_i,
    input  logic [ADDR_WIDTH-1:0]        clr_rd_i,
`ifdef RF_WB_BYPASS_EN
    output logic                         byp_rs1_hit_o,
    output logic                         byp_rs2_hit_o,
`endif
    output logic [(1<<ADDR_WIDTH)-1:0]   busy_o,
    output logic                         iss_hazard_o
);

    localparam int NREGS = 1 << ADDR_WIDTH;

    logic [NREGS-1:0] busy_q, busy_d;
    logic             set_en;
    logic             rs1_busy, rs2_busy, rd_busy;

`ifdef RF_WB_BYPASS_EN
    logic hit1, hit2;

    // clr_en/clr_rd is the live write port, so its value is forwardable now
    always_comb begin
        hit1     = clr_en_i && (clr_rd_i == iss_rs1_i) && (iss_rs1_i != '0);
        hit2     = clr_en_i && (clr_rd_i == iss_rs2_i) && (iss_rs2_i != '0);
        rs1_busy = busy_q[iss_rs1_i] && !hit1;
        rs2_busy = busy_q[iss_rs2_i] && !hit2;
    end

    assign byp_rs1_hit_o = hit1;
    assign byp_rs2_hit_o = hit2;
`else
    always_comb begin
        rs1_busy = busy_q[iss_rs1_i];
        rs2_busy = busy_q[iss_rs2_i];
    end
`endif

    assign rd_busy      = busy_q[iss_rd_i];
    assign iss_hazard_o = rs1_busy || rs2_busy || rd_busy;
    assign set_en       = iss_valid_i && !iss_hazard_o && (iss_rd_i != '0);

    always_comb begin
        busy_d = busy_q;
        if (clr_en_i) busy_d[clr_rd_i] = 1'b0;
        if (set_en)   busy_d[iss_rd_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/rf_writeback.sv
// RF write-port arbiter (LSU over ALU), registered write stage, writeback counter and scoreboard.
// RF_WB_BYPASS_EN adds byp_rs1_hit/byp_rs2_hit/byp_data so decode can read the value being written.
module rf_writeback
    import rf_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_W,
    parameter int DATA_WIDTH = RF_DATA_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         iss_valid,
    input  logic [ADDR_WIDTH-1:0]        iss_rd,
    input  logic [ADDR_WIDTH-1:0]        iss_rs1,
    input  logic [ADDR_WIDTH-1:0]        iss_rs2,
    output logic                         iss_hazard,
    input  logic                         alu_valid,
    input  logic [ADDR_WIDTH-1:0]        alu_rd,
    input  logic [DATA_WIDTH-1:0]        alu_data,
    output logic                         alu_ready,
    input  logic                         lsu_valid,
    input  logic [ADDR_WIDTH-1:0]        lsu_rd,
    input  logic [DATA_WIDTH-1:0]        lsu_data,
    output logic                         lsu_ready,
    output logic                         rf_wen,
    output logic [ADDR_WIDTH-1:0]        rf_rd,
    output logic [DATA_WIDTH-1:0]        rf_wdata,
`ifdef RF_WB_BYPASS_EN
    output logic                         byp_rs1_hit,
    output logic                         byp_rs2_hit,
    output logic [DATA_WIDTH-1:0]        byp_data,
`endif
    output logic [(1<<ADDR_WIDTH)-1:0]   busy,
    output logic [31:0]                  wb_count
);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0] data;
    } wb_stage_t;

    wb_stage_t   acc_req, wb_q, wb_d;
    logic        acc_valid, wen_d, rf_wen_q;
    logic [31:0] wb_count_q, wb_count_d;

    assign lsu_ready = 1'b1;
    assign alu_ready = !lsu_valid;

    always_comb begin
        acc_valid = lsu_valid || (alu_valid && alu_ready);
        if (lsu_valid) begin
            acc_req.rd   = lsu_rd;
            acc_req.data = lsu_data;
        end else begin
            acc_req.rd   = alu_rd;
            acc_req.data = alu_data;
        end
        // rd==0 results are consumed but never reach the RF port
        wen_d      = acc_valid && (acc_req.rd != '0);
        wb_d       = wen_d ? acc_req : wb_q;
        wb_count_d = wb_count_q + {31'b0, rf_wen_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wen_q   <= 1'b0;
            wb_q       <= '0;
            wb_count_q <= '0;
        end else begin
            rf_wen_q   <= wen_d;
            wb_q       <= wb_d;
            wb_count_q <= wb_count_d;
        end
    end

    assign rf_wen   = rf_wen_q;
    assign rf_rd    = wb_q.rd;
    assign rf_wdata = wb_q.data;
    assign wb_count = wb_count_q;

    rf_scoreboard #(.ADDR_WIDTH(ADDR_WIDTH)) u_sb (
        .clk          (clk),
        .rst          (rst),
        .iss_valid_i  (iss_valid),
        .iss_rd_i     (iss_rd),
        .iss_rs1_i    (iss_rs1),
        .iss_rs2_i    (iss_rs2),
        .clr_en_i     (rf_wen_q),
        .clr_rd_i     (wb_q.rd),
`ifdef RF_WB_BYPASS_EN
        .byp_rs1_hit_o(byp_rs1_hit),
        .byp_rs2_hit_o(byp_rs2_hit),
`endif
        .busy_o       (busy),
        .iss_hazard_o (iss_hazard)
    );

`ifdef RF_WB_BYPASS_EN
    assign byp_data = wb_q.data;
`endif

    // Decode must never issue into a hazard
    a_no_issue_on_hazard: assert property (@(posedge clk) disable iff (rst)
        !(iss_valid && iss_hazard));

    // A result should only arrive for a destination that decode allocated
    a_result_was_allocated: assert property (@(posedge clk) disable iff (rst)
        (acc_valid && (acc_req.rd != '0)) |-> busy[acc_req.rd]);

endmodule

// File: tb/tb_rf_writeback.sv
// Directed bench for rf_writeback plus a standalone scoreboard for the set/clear collision case.
module tb_rf_writeback;
    import rf_pkg::*;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          iss_valid;
    logic [AW-1:0] iss_rd, iss_rs1, iss_rs2;
    logic          iss_hazard;
    logic          alu_valid;
    logic [AW-1:0] alu_rd;
    logic [DW-1:0] alu_data;
    logic          alu_ready;
    logic          lsu_valid;
    logic [AW-1:0] lsu_rd;
    logic [DW-1:0] lsu_data;
    logic          lsu_ready;
    logic          rf_wen;
    logic [AW-1:0] rf_rd;
    logic [DW-1:0] rf_wdata;
    logic [31:0]   busy;
    logic [31:0]   wb_count;
`ifdef RF_WB_BYPASS_EN
    logic          byp_rs1_hit, byp_rs2_hit;
    logic [DW-1:0] byp_data;
    logic          sb_byp1, sb_byp2;
`endif

    logic          sb_iss_valid, sb_clr_en, sb_hazard;
    logic [AW-1:0] sb_iss_rd, sb_clr_rd;
    logic [31:0]   sb_busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rf_writeback #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .iss_valid  (iss_valid),
        .iss_rd     (iss_rd),
        .iss_rs1    (iss_rs1),
        .iss_rs2    (iss_rs2),
        .iss_hazard (iss_hazard),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .alu_ready  (alu_ready),
        .lsu_valid  (lsu_valid),
        .lsu_rd     (lsu_rd),
        .lsu_data   (lsu_data),
        .lsu_ready  (lsu_ready),
        .rf_wen     (rf_wen),
        .rf_rd      (rf_rd),
        .rf_wdata   (rf_wdata),
`ifdef RF_WB_BYPASS_EN
        .byp_rs1_hit(byp_rs1_hit),
        .byp_rs2_hit(byp_rs2_hit),
        .byp_data   (byp_data),
`endif
        .busy       (busy),
        .wb_count   (wb_count)
    );

    rf_scoreboard #(.ADDR_WIDTH(AW)) u_sb_chk (
        .clk          (clk),
        .rst          (rst),
        .iss_valid_i  (sb_iss_valid),
        .iss_rd_i     (sb_iss_rd),
        .iss_rs1_i    (5'd0),
        .iss_rs2_i    (5'd0),
        .clr_en_i     (sb_clr_en),
        .clr_rd_i     (sb_clr_rd),
`ifdef RF_WB_BYPASS_EN
        .byp_rs1_hit_o(sb_byp1),
        .byp_rs2_hit_o(sb_byp2),
`endif
        .busy_o       (sb_busy),
        .iss_hazard_o (sb_hazard)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [AW-1:0] rd);
        iss_valid = 1'b1;
        iss_rd    = rd;
        step();
        iss_valid = 1'b0;
        iss_rd    = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        iss_valid = 0; iss_rd = 0; iss_rs1 = 0; iss_rs2 = 0;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
        sb_iss_valid = 0; sb_iss_rd = 0; sb_clr_en = 0; sb_clr_rd = 0;
        step();
        step();
        rst = 1'b0;

        // 1: idle after reset
        for (int i = 0; i < 10; i++) begin
            chk("idle_busy", busy, 0);
            chk("idle_wen", rf_wen, 0);
            chk("idle_cnt", wb_count, 0);
            chk("idle_alu_rdy", alu_ready, 1);
            chk("idle_lsu_rdy", lsu_ready, 1);
            step();
        end
        chk("rst_rd", rf_rd, 0);
        chk("rst_wdata", rf_wdata, 0);

        // 2: issue rd=5, hazard on rs1=5, ALU write and clear
        iss_valid = 1'b1; iss_rd = 5'd5;
        #1 chk("s2_iss_nohaz", iss_hazard, 0);
        step();
        iss_valid = 1'b0; iss_rd = 0;
        chk("s2_busy5_set", busy, 32'h0000_0020);
        iss_rs1 = 5'd5;
        #1 chk("s2_rs1_hazard", iss_hazard, 1);
        step();
        step();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
        #1 chk("s2_alu_rdy", alu_ready, 1);
        chk("s2_wen_lat", rf_wen, 0);
        step();
        alu_valid = 1'b0;
        #1;
        chk("s2_wen", rf_wen, 1);
        chk("s2_rd", rf_rd, 5);
        chk("s2_wdata", rf_wdata, 32'hDEAD_BEEF);
        chk("s2_busy_hold", busy[5], 1);
        chk("s2_cnt_before", wb_count, 0);
`ifdef RF_WB_BYPASS_EN
        chk("s2_byp_haz", iss_hazard, 0);
        chk("s2_byp_hit1", byp_rs1_hit, 1);
        chk("s2_byp_hit2", byp_rs2_hit, 0);
        chk("s2_byp_data", byp_data, 32'hDEAD_BEEF);
`else
        chk("s2_stall_haz", iss_hazard, 1);
`endif
        step();
        chk("s2_busy_clr", busy, 0);
        chk("s2_cnt", wb_count, 1);
        chk("s2_wen_off", rf_wen, 0);
        chk("s2_haz_off", iss_hazard, 0);
        iss_rs1 = 0;

        // 3: ALU and LSU collide, LSU first
        issue(5'd3);
        issue(5'd4);
        chk("s3_busy", busy, 32'h0000_0018);
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h3333_3333;
        lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h4444_4444;
        #1 chk("s3_alu_blocked", alu_ready, 0);
        chk("s3_lsu_rdy", lsu_ready, 1);
        step();
        lsu_valid = 1'b0;
        #1;
        chk("s3_wen1", rf_wen, 1);
        chk("s3_rd1", rf_rd, 4);
        chk("s3_data1", rf_wdata, 32'h4444_4444);
        chk("s3_alu_rdy", alu_ready, 1);
        step();
        alu_valid = 1'b0;
        chk("s3_wen2", rf_wen, 1);
        chk("s3_rd2", rf_rd, 3);
        chk("s3_data2", rf_wdata, 32'h3333_3333);
        step();
        chk("s3_cnt", wb_count, 3);
        chk("s3_busy_clr", busy, 0);
        chk("s3_wen_off", rf_wen, 0);

        // 4: rd=0 result is swallowed
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234;
        #1 chk("s4_alu_rdy", alu_ready, 1);
        step();
        alu_valid = 1'b0;
        chk("s4_no_wen", rf_wen, 0);
        step();
        chk("s4_cnt", wb_count, 3);
        chk("s4_busy0", busy[0], 0);
        chk("s4_busy", busy, 0);

        // 5: set and clear of the same index on one edge, set wins
        sb_clr_en = 1'b1; sb_clr_rd = 5'd7;
        sb_iss_valid = 1'b1; sb_iss_rd = 5'd7;
        #1 chk("s5_nohaz", sb_hazard, 0);
        step();
        sb_iss_valid = 1'b0; sb_iss_rd = 0;
        chk("s5_set_wins", sb_busy, 32'h0000_0080);
        step();
        sb_clr_en = 1'b0;
        chk("s5_clear", sb_busy, 0);

        // 6: reset while a write is on the port and busy=0xF0
        issue(5'd4);
        issue(5'd5);
        issue(5'd6);
        issue(5'd7);
        chk("s6_busy", busy, 32'h0000_00F0);
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'hAAAA_5555;
        step();
        alu_valid = 1'b0;
        chk("s6_pending", rf_wen, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("s6_wen_drop", rf_wen, 0);
        chk("s6_busy_rst", busy, 0);
        chk("s6_cnt_rst", wb_count, 0);
        chk("s6_rd_rst", rf_rd, 0);
        step();
        chk("s6_wen_idle", rf_wen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
